// File: rtl/serial_word_deserializer_pkg.sv
// Shared types and constants for the serial word deserializer.
package deser_pkg;
    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} deser_state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;
endpackage

// File: rtl/serial_word_deserializer_if.sv
// Serial input, parallel output and error-flag bundle for the deserializer.
interface serial_word_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             ser_in;
    logic             ser_valid;
    logic             ser_start;
    logic             msb_first;
    logic [WIDTH-1:0] p_out;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             frame_err;
    logic             err_clr;

    modport slave (
        input  ser_in, ser_valid, ser_start, msb_first, out_ready, err_clr,
        output p_out, out_valid, overrun, frame_err
    );

    modport master (
        output ser_in, ser_valid, ser_start, msb_first, out_ready, err_clr,
        input  p_out, out_valid, overrun, frame_err
    );
endinterface

// File: rtl/serial_word_deserializer_shift_core.sv
// Shift register, bit counter and latched bit order; flags the bit that completes a word.
module deser_shift_core
    import deser_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic             ser_in,
    input  logic             msb_first,
    output logic             word_done,
    output logic [WIDTH-1:0] word
);
    logic [WIDTH-1:0] sh;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic             last_pos;

    // Widen by one bit so the shift works for WIDTH=1 without empty slices.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic b, input logic dir);
        logic [WIDTH:0] t;
        if (dir == DIR_MSB_FIRST) begin
            t = {cur, b};
            return t[WIDTH-1:0];
        end else begin
            t = {b, cur};
            return t[WIDTH:1];
        end
    endfunction

    assign last_pos  = (cnt == CNT_W'(WIDTH - 1));
    assign word      = load ? shift_in('0, ser_in, msb_first) : shift_in(sh, ser_in, dir_q);
    assign word_done = load ? (WIDTH == 1) : (shift_en && last_pos);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            sh    <= '0;
            cnt   <= '0;
            dir_q <= DIR_LSB_FIRST;
        end else if (load) begin
            sh    <= word;
            cnt   <= (WIDTH == 1) ? '0 : CNT_W'(1);
            dir_q <= msb_first;
        end else if (shift_en) begin
            sh    <= word;
            cnt   <= last_pos ? '0 : cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word receiver: framing FSM, one-word output register, sticky error flags.
module serial_word_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic clear_n,
    serial_word_deserializer_if.slave bus
);
    localparam logic [0:0] ST_IDLE  = 1'(IDLE);
    localparam logic [0:0] ST_SHIFT = 1'(SHIFT);

    logic [0:0]       state;
    logic             load, shift_en, word_done;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] p_out_q;
    logic             out_valid_q, overrun_q, frame_err_q;
    logic             accept, drop, resync;

    // A start bit always begins a new word, even in the middle of one.
    assign load     = bus.ser_valid & bus.ser_start;
    assign shift_en = bus.ser_valid & ~bus.ser_start & (state == ST_SHIFT);
    assign resync   = load & (state == ST_SHIFT);

    deser_shift_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .clear_n   (clear_n),
        .load      (load),
        .shift_en  (shift_en),
        .ser_in    (bus.ser_in),
        .msb_first (bus.msb_first),
        .word_done (word_done),
        .word      (word)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n)
            state <= ST_IDLE;
        else if (load)
            state <= (WIDTH == 1) ? ST_IDLE : ST_SHIFT;
        else if (word_done)
            state <= ST_IDLE;
    end

    // The output register frees up on the same edge it is read, so drain and fill can coincide.
    assign accept = word_done & (~out_valid_q | bus.out_ready);
    assign drop   = word_done & out_valid_q & ~bus.out_ready;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            p_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            p_out_q     <= word;
            out_valid_q <= 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (drop)             overrun_q   <= 1'b1;
            else if (bus.err_clr) overrun_q   <= 1'b0;
            if (resync)           frame_err_q <= 1'b1;
            else if (bus.err_clr) frame_err_q <= 1'b0;
        end
    end

    assign bus.p_out     = p_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench for serial_word_deserializer: directed cases plus random traffic vs a bit-list model.
module tb_serial_word_deserializer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    always #5 clk = ~clk;

    serial_word_deserializer_if #(.WIDTH(W)) bus();

    serial_word_deserializer #(.WIDTH(W)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: list of bits of the current word, one-deep output holding flag.
    int exp_q[$];
    int m_bits[$];
    bit m_dir, m_active, m_pend, m_ovr, m_fe;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic int word_of(input int bits[$], input bit dir);
        int v = 0;
        for (int k = 0; k < W; k++)
            if (dir) v += bits[k] * (1 << (W - 1 - k));
            else     v += bits[k] * (1 << k);
        return v;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        exp_q.delete();
        m_dir = 0; m_active = 0; m_pend = 0; m_ovr = 0; m_fe = 0;
    endtask

    task automatic set_idle();
        bus.ser_in = 0; bus.ser_valid = 0; bus.ser_start = 0;
        bus.msb_first = 0; bus.out_ready = 0; bus.err_clr = 0;
    endtask

    // One clock of stimulus: check state left by the previous edge, then apply inputs for the next.
    task automatic step(input bit v, input bit b, input bit s, input bit m,
                        input bit rdy, input bit ec);
        bit done, fe_set, ovr_set, xfer;
        int wv;
        @(posedge clk); #1;
        chk("out_valid", int'(bus.out_valid), int'(m_pend));
        chk("overrun",   int'(bus.overrun),   int'(m_ovr));
        chk("frame_err", int'(bus.frame_err), int'(m_fe));
        bus.ser_valid = v; bus.ser_in = b; bus.ser_start = s;
        bus.msb_first = m; bus.out_ready = rdy; bus.err_clr = ec;
        done = 0; fe_set = 0; wv = 0;
        if (v) begin
            if (s) begin
                if (m_active) fe_set = 1;
                m_bits.delete();
                m_bits.push_back(int'(b));
                m_dir = m;
                m_active = 1;
            end else if (m_active) begin
                m_bits.push_back(int'(b));
            end
            if (m_active && m_bits.size() == W) begin
                done = 1;
                wv = word_of(m_bits, m_dir);
                m_active = 0;
            end
        end
        xfer    = m_pend && rdy;
        ovr_set = done && m_pend && !rdy;
        if (done && (!m_pend || rdy)) begin
            exp_q.push_back(wv);
            m_pend = 1;
        end else if (xfer) begin
            m_pend = 0;
        end
        if (ovr_set) m_ovr = 1; else if (ec) m_ovr = 0;
        if (fe_set)  m_fe  = 1; else if (ec) m_fe  = 0;
    endtask

    task automatic send_word(input int val, input bit msb, input bit rdy);
        bit b;
        for (int k = 0; k < W; k++) begin
            b = msb ? bit'((val >> (W - 1 - k)) & 1) : bit'((val >> k) & 1);
            step(1, b, k == 0, msb, rdy, 0);
        end
    endtask

    // Monitor: every accepted word must match the oldest expected one.
    always @(negedge clk) begin
        if (clear_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL sb_underflow: got %0d expected none at %0t", bus.p_out, $time);
            end else begin
                chk("sb_word", int'(bus.p_out), exp_q.pop_front());
            end
        end
    end

    initial begin
        set_idle();
        model_reset();
        #1;
        chk("rst_p_out", int'(bus.p_out), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_overrun", int'(bus.overrun), 0);
        chk("rst_frame_err", int'(bus.frame_err), 0);
        #12 clear_n = 1'b1;

        // MSB-first basic: 1,0,1,0 -> 1010
        step(1, 1, 1, 1, 1, 0); step(1, 0, 0, 1, 1, 0);
        step(1, 1, 0, 1, 1, 0); step(1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("basic_p_out", int'(bus.p_out), 4'b1010);
        chk("basic_valid", int'(bus.out_valid), 1);
        step(0, 0, 0, 0, 1, 0);

        // LSB-first with gaps: 0,1,0,1 -> 1010
        step(1, 0, 1, 0, 1, 0); step(0, 0, 0, 1, 1, 0); step(0, 1, 0, 1, 1, 0);
        step(1, 1, 0, 1, 1, 0); step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0); step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 1, 1, 0); step(0, 0, 0, 0, 1, 0);
        chk("lsb_p_out", int'(bus.p_out), 4'b1010);
        step(0, 0, 0, 0, 1, 0);

        // Backpressure and overrun
        send_word(4'b1100, 1, 0);
        send_word(4'b0011, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("ovr_p_out", int'(bus.p_out), 4'b1100);
        chk("ovr_flag", int'(bus.overrun), 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("ovr_cleared", int'(bus.overrun), 0);

        // Same-edge drain and fill
        step(1, 0, 1, 1, 0, 0); step(1, 1, 0, 1, 0, 0); step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("fill_p_out", int'(bus.p_out), 4'b0101);
        chk("fill_valid", int'(bus.out_valid), 1);
        chk("fill_overrun", int'(bus.overrun), 0);
        step(0, 0, 0, 0, 1, 0);

        // Resync: partial word, then start with 1,1,1,0
        step(1, 0, 1, 1, 1, 0); step(1, 1, 0, 1, 1, 0);
        send_word(4'b1110, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("resync_ferr", int'(bus.frame_err), 1);
        chk("resync_p_out", int'(bus.p_out), 4'b1110);
        step(0, 0, 0, 0, 1, 1);

        // Start on the last bit position wins
        step(1, 1, 1, 1, 1, 0); step(1, 1, 0, 1, 1, 0); step(1, 1, 0, 1, 1, 0);
        send_word(4'b1001, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("laststart_p_out", int'(bus.p_out), 4'b1001);
        step(0, 0, 0, 0, 1, 1);

        // Reset mid-word, with a word held
        send_word(4'b0111, 1, 0);
        step(1, 1, 1, 1, 0, 0); step(1, 1, 0, 1, 0, 0);
        #2;
        set_idle();
        clear_n = 1'b0;
        #1;
        chk("mid_rst_p_out", int'(bus.p_out), 0);
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_overrun", int'(bus.overrun), 0);
        chk("mid_rst_ferr", int'(bus.frame_err), 0);
        model_reset();
        @(posedge clk); #1 clear_n = 1'b1;
        send_word(4'b0110, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        chk("post_rst_p_out", int'(bus.p_out), 4'b0110);
        chk("post_rst_ferr", int'(bus.frame_err), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(9) < 7, 1'($urandom), $urandom_range(9) == 0,
                 1'($urandom), $urandom_range(3) != 0, $urandom_range(19) == 0);

        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0);
        chk("sb_leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
